spike_event_writer: RTL and testbench

SPIKE_EVENT_WRITER -- requirements
Module: spike_event_writer

---
 rtl/spike_event_writer.sv | 141 ++++++++++++++
 tb/tb_spike_event_writer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_writer.sv
// rtl/spike_event_writer.sv - scans a spike bitmap row by row and writes set-bit indices plus an end-of-frame token to a FIFO
module spike_event_writer #(
    parameter int ROWS   = 28,
    parameter int WORD_W = 28,
    parameter int ROW_W  = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ROW_W-1:0]  mem_addr,
    input  logic [WORD_W-1:0] mem_data,
    input  logic              full,
    input  logic              almost_full,
    output logic              w_en,
    output logic [15:0]       s_index_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WAIT, S_SCAN, S_EOF, S_DONE
    } state_t;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [15:0]      EOF_TOK  = 16'hFFFF;

    state_t             state_q;
    logic [ROW_W-1:0]   row_q;
    logic [15:0]        base_q;
    logic [WORD_W-1:0]  word_q;
    logic [15:0]        last_q;
    logic               busy_q;
    logic               done_q;
    logic               mem_rd_en_q;
    logic [ROW_W-1:0]   mem_addr_q;

    logic               unused_af;
    logic               word_nz;
    logic [WORD_W-1:0]  word_clr;
    logic [15:0]        low_b;
    logic [15:0]        scan_idx;
    logic               scan_wr;
    logic               eof_wr;

    assign unused_af = almost_full;

    // Descending loop so the lowest set bit is the last assignment to win.
    always_comb begin
        low_b = 16'd0;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            if (word_q[i]) begin
                low_b = 16'(i);
            end
        end
    end

    assign word_nz  = |word_q;
    assign word_clr = word_q & (word_q - {{(WORD_W-1){1'b0}}, 1'b1});
    assign scan_idx = base_q + low_b;

    // The write strobe is qualified by the current full so a write never lands on a full FIFO.
    assign scan_wr = (state_q == S_SCAN) && word_nz && !full;
    assign eof_wr  = (state_q == S_EOF) && !full;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            base_q      <= 16'd0;
            word_q      <= '0;
            last_q      <= 16'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q     <= S_RD;
                        row_q       <= '0;
                        base_q      <= 16'd0;
                        word_q      <= '0;
                        busy_q      <= 1'b1;
                        mem_rd_en_q <= 1'b1;
                        mem_addr_q  <= '0;
                    end
                end
                S_RD: begin
                    mem_rd_en_q <= 1'b0;
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    word_q  <= mem_data;
                    state_q <= S_SCAN;
                end
                S_SCAN: begin
                    if (word_nz) begin
                        if (scan_wr) begin
                            word_q <= word_clr;
                            last_q <= scan_idx;
                        end
                    end else if (row_q == LAST_ROW) begin
                        state_q <= S_EOF;
                    end else begin
                        row_q       <= row_q + 1'b1;
                        base_q      <= base_q + 16'(WORD_W);
                        mem_rd_en_q <= 1'b1;
                        mem_addr_q  <= row_q + 1'b1;
                        state_q     <= S_RD;
                    end
                end
                S_EOF: begin
                    if (eof_wr) begin
                        last_q  <= EOF_TOK;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;
    assign w_en      = scan_wr || eof_wr;
    assign s_index_o = scan_wr ? scan_idx : (eof_wr ? EOF_TOK : last_q);

endmodule

// File: tb/tb_spike_event_writer.sv
// tb/tb_spike_event_writer.sv - directed self-checking bench for spike_event_writer
module tb_spike_event_writer;

    localparam int ROWS   = 28;
    localparam int WORD_W = 28;
    localparam int ROW_W  = 5;

    logic              clk = 1'b0;
    logic              rstn;
    logic              start;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ROW_W-1:0]  mem_addr;
    logic [WORD_W-1:0] mem_data;
    logic              full;
    logic              almost_full;
    logic              w_en;
    logic [15:0]       s_index_o;

    logic [WORD_W-1:0] rows_mem [ROWS];
    logic [15:0]       wq [$];
    int                cyc;
    int                done_cyc;
    int                first_rd;
    int                viol;
    int                eof_cnt;
    logic              busy_at_done;
    int                n_vec;
    int                n_bad;

    spike_event_writer #(.ROWS(ROWS), .WORD_W(WORD_W), .ROW_W(ROW_W)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .full        (full),
        .almost_full (almost_full),
        .w_en        (w_en),
        .s_index_o   (s_index_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd_en) mem_data <= rows_mem[mem_addr];
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (w_en) begin
                wq.push_back(s_index_o);
                if (full) viol = viol + 1;
                if (s_index_o == 16'hFFFF) eof_cnt = eof_cnt + 1;
            end
            if (done) begin
                done_cyc     = cyc;
                busy_at_done = busy;
            end
            if (mem_rd_en && first_rd < 0) first_rd = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rec();
        wq.delete();
        done_cyc = -1;
        first_rd = -1;
        eof_cnt  = 0;
        busy_at_done = 1'b1;
    endtask

    task automatic clear_rows();
        for (int r = 0; r < ROWS; r++) rows_mem[r] = '0;
    endtask

    task automatic pulse_start(output int start_cyc);
        start = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cyc < 0 && n < budget) begin
            tick();
            n++;
        end
        n_vec++;
        if (done_cyc < 0) begin
            n_bad++;
            $display("FAIL done_timeout: actual no done, required done within %0d cycles", budget);
        end
        tick();
    endtask

    task automatic check_q(input string name, input logic [15:0] exp [$]);
        string s;
        n_vec++;
        if (wq.size() != exp.size()) begin
            n_bad++;
            $display("FAIL %s_count: actual %0d writes, required %0d", name, wq.size(), exp.size());
        end else begin
            foreach (exp[i]) begin
                if (wq[i] !== exp[i]) begin
                    n_bad++;
                    $display("FAIL %s[%0d]: actual %0d, required %0d", name, i, wq[i], exp[i]);
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        n_vec++;
        if ({busy, done, mem_rd_en, mem_addr, w_en, s_index_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: actual busy=%b done=%b rd=%b addr=%0d w_en=%b idx=%0d, required all 0",
                     busy, done, mem_rd_en, mem_addr, w_en, s_index_o);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_row0_two_bits();
        int sc;
        clear_rows();
        rows_mem[0] = 28'h0000005;
        clear_rec();
        pulse_start(sc);
        wait_done(200);
        check_q("row0", '{16'd0, 16'd2, 16'hFFFF});
        n_vec++;
        if (busy_at_done !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_in_done: actual %b, required 0", busy_at_done);
        end
    endtask

    task automatic test_last_bit();
        int sc;
        clear_rows();
        rows_mem[27] = 28'h8000000;
        clear_rec();
        pulse_start(sc);
        wait_done(200);
        check_q("last_bit", '{16'd783, 16'hFFFF});
        n_vec++;
        if (done_cyc - first_rd != 86) begin
            n_bad++;
            $display("FAIL last_bit_latency: actual %0d, required 86", done_cyc - first_rd);
        end
    endtask

    task automatic test_backpressure();
        int sc;
        int n;
        clear_rows();
        rows_mem[1] = 28'h000000F;
        clear_rec();
        viol = 0;
        pulse_start(sc);
        n = 0;
        while (w_en !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        tick();
        full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_vec++;
            if (w_en !== 1'b0) begin
                n_bad++;
                $display("FAIL full_hold[%0d]: actual w_en=%b, required 0", i, w_en);
            end
            tick();
        end
        full = 1'b0;
        wait_done(200);
        check_q("backpressure", '{16'd28, 16'd29, 16'd30, 16'd31, 16'hFFFF});
        n_vec++;
        if (viol != 0) begin
            n_bad++;
            $display("FAIL wen_while_full: actual %0d, required 0", viol);
        end
    endtask

    task automatic test_all_zero();
        int sc;
        clear_rows();
        clear_rec();
        pulse_start(sc);
        wait_done(200);
        check_q("all_zero", '{16'hFFFF});
        n_vec++;
        if (done_cyc - sc != ROWS * 3 + 2) begin
            n_bad++;
            $display("FAIL all_zero_span: actual %0d, required %0d", done_cyc - sc, ROWS * 3 + 2);
        end
    endtask

    task automatic test_eof_stall();
        int sc;
        clear_rows();
        clear_rec();
        full = 1'b1;
        pulse_start(sc);
        for (int i = 0; i < 150; i++) tick();
        n_vec++;
        if (busy !== 1'b1 || wq.size() != 0 || done_cyc >= 0) begin
            n_bad++;
            $display("FAIL eof_stall: actual busy=%b writes=%0d done_seen=%0d, required busy=1 writes=0 no done",
                     busy, wq.size(), done_cyc >= 0);
        end
        full = 1'b0;
        wait_done(20);
        check_q("eof_stall", '{16'hFFFF});
    endtask

    task automatic test_reset_mid_frame();
        int sc;
        int n;
        clear_rows();
        rows_mem[0] = 28'h0000001;
        rows_mem[3] = 28'h0000011;
        clear_rec();
        full = 1'b1;
        pulse_start(sc);
        n = 0;
        while (!(mem_rd_en === 1'b1 && mem_addr == 3) && n < 50) begin
            if (n == 2) full = 1'b0;
            tick();
            n++;
        end
        full = 1'b1;
        tick();
        tick();
        rstn = 1'b0;
        tick();
        full = 1'b0;
        n_vec++;
        if ({busy, done, mem_rd_en, mem_addr, w_en, s_index_o} !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: actual busy=%b done=%b rd=%b addr=%0d w_en=%b idx=%0d, required all 0",
                     busy, done, mem_rd_en, mem_addr, w_en, s_index_o);
        end
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check_q("aborted", '{16'd0});
        clear_rec();
        pulse_start(sc);
        wait_done(200);
        check_q("restart", '{16'd0, 16'd84, 16'd88, 16'hFFFF});
    endtask

    task automatic test_start_ignored();
        int sc;
        int dummy;
        int n;
        clear_rows();
        rows_mem[2] = 28'h0000002;
        clear_rec();
        pulse_start(sc);
        for (int i = 0; i < 10; i++) tick();
        pulse_start(dummy);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        pulse_start(dummy);
        for (int i = 0; i < 120; i++) tick();
        check_q("start_ignored", '{16'd57, 16'hFFFF});
        n_vec++;
        if (eof_cnt != 1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_eof: actual eof=%0d busy=%b, required eof=1 busy=0", eof_cnt, busy);
        end
    endtask

    initial begin
        rstn = 1'b0;
        start = 1'b0;
        full = 1'b0;
        almost_full = 1'b0;
        mem_data = '0;
        cyc = 0;
        viol = 0;
        n_vec = 0;
        n_bad = 0;
        clear_rows();
        clear_rec();
        test_reset();
        test_row0_two_bits();
        test_last_bit();
        test_backpressure();
        test_all_zero();
        test_eof_stall();
        test_reset_mid_frame();
        test_start_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
